// File: rtl/apb_pkg.sv
// apb_pkg
// Shared APB definitions used by the completer and by the bridge bench.
//   completer_state_e : completer FSM states (IDLE, ACCESS, ABORT)
//   PROT_PRIV/PROT_NSEC/PROT_INSTR : bit positions inside pprot
//   required_prot()   : maps the protection field from the top of paddr onto pprot bits
//   addr_aligned()    : word-alignment test on the two low address bits
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ABORT  = 2'd2
    } completer_state_e;

    localparam int PROT_PRIV  = 0;
    localparam int PROT_NSEC  = 1;
    localparam int PROT_INSTR = 2;

    // The three most significant address bits name the pprot attributes a
    // region demands; the lowest of them corresponds to the privileged bit.
    function automatic logic [2:0] required_prot(input logic [2:0] protField);
        logic [2:0] req;
        req             = '0;
        req[PROT_PRIV]  = protField[0];
        req[PROT_NSEC]  = protField[1];
        req[PROT_INSTR] = protField[2];
        return req;
    endfunction

    function automatic logic addr_aligned(input logic [1:0] addrLsbs);
        return (addrLsbs == 2'b00);
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// apb_regfile
// NUM_REGS x DATA_WIDTH register storage for the APB completer.
//   clock_i  : clock, all updates on posedge
//   reset_i  : synchronous active-high reset, clears every register
//   we_i     : write enable
//   waddr_i  : write register index
//   wstrb_i  : per-byte write enables
//   wdata_i  : write data
//   raddr_i  : read register index
//   rdata_o  : combinational read data
module apb_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             we_i,
    input  logic [$clog2(NUM_REGS)-1:0]      waddr_i,
    input  logic [DATA_WIDTH/8-1:0]          wstrb_i,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    input  logic [$clog2(NUM_REGS)-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0]            rdata_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

    // Storage update: reset wipes the whole file, otherwise only the
    // byte lanes enabled by the strobe are overwritten.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_completer.sv
// apb_completer
// APB4 completer serving reads/writes to a small register file, with
// alignment, range, protection and signal-stability checks reported on pslverr.
// Optional feature macro: APB_PSTRB_EN (honour pstrb on writes, reject reads
// with a non-zero strobe). Without it pstrb is ignored and writes are full-word.
//   pclk, reset            : clock and synchronous active-high reset
//   psel, penable, pwrite  : APB control
//   paddr, pwdata, pstrb   : address, write data, byte strobes
//   pprot                  : protection attributes
//   prdata, pready, pslverr: response, decoded from registered state only
module apb_completer
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                    pclk,
    input  logic                    reset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    completer_state_e        state_q;
    logic [CNT_W-1:0]        waitCnt_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [2:0]              pprot_q;
    logic                    err_q;

    logic                    setupErr;
    logic [2:0]              reqProt;
    logic                    fieldsChanged;
    logic                    completing;
    logic                    commitWr;
    logic [STRB_W-1:0]       wrStrb;
    logic [DATA_WIDTH-1:0]   rdData;

`ifdef APB_PSTRB_EN
    logic [STRB_W-1:0]       pstrb_q;
    assign wrStrb = pstrb_q;
`else
    logic                    unusedPstrb;
    assign unusedPstrb = ^pstrb;
    assign wrStrb      = '1;
`endif

    // Static checks evaluated on the SETUP-phase inputs; the outcome is
    // latched with the request so the response never depends on live inputs.
    always_comb begin
        setupErr = 1'b0;
        reqProt  = required_prot(paddr[ADDR_WIDTH-1 -: 3]);
        if (!addr_aligned(paddr[1:0])) begin
            setupErr = 1'b1;
        end
        if (paddr[ADDR_WIDTH-4:2+IDX_W] != '0) begin
            setupErr = 1'b1;
        end
        if ((pprot & reqProt) != reqProt) begin
            setupErr = 1'b1;
        end
`ifdef APB_PSTRB_EN
        if (!pwrite && (pstrb != '0)) begin
            setupErr = 1'b1;
        end
`endif
    end

    assign fieldsChanged = (paddr != paddr_q) || (pwrite != pwrite_q) || (pprot != pprot_q);
    assign completing    = (state_q == ACCESS) && (waitCnt_q == '0);
    assign commitWr      = completing && psel && penable && pwrite_q && !err_q;

    // Transfer sequencing. The stability check runs on every ACCESS cycle
    // that precedes the completing one and sets the sticky error flag, so an
    // unstable request is reported without a combinational input->output path.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pprot_q   <= '0;
            err_q     <= 1'b0;
`ifdef APB_PSTRB_EN
            pstrb_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        paddr_q   <= paddr;
                        pwrite_q  <= pwrite;
                        pwdata_q  <= pwdata;
                        pprot_q   <= pprot;
                        err_q     <= setupErr;
                        waitCnt_q <= CNT_W'(WAIT_STATES);
                        state_q   <= ACCESS;
`ifdef APB_PSTRB_EN
                        pstrb_q   <= pstrb;
`endif
                    end
                end
                ACCESS: begin
                    if (!(psel && penable)) begin
                        state_q <= ABORT;
                    end else if (waitCnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        waitCnt_q <= waitCnt_q - CNT_W'(1);
                        if (fieldsChanged) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    apb_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clock_i (pclk),
        .reset_i (reset),
        .we_i    (commitWr),
        .waddr_i (paddr_q[IDX_W+1:2]),
        .wstrb_i (wrStrb),
        .wdata_i (pwdata_q),
        .raddr_i (paddr_q[IDX_W+1:2]),
        .rdata_o (rdData)
    );

    // Response decode: an abort always errors with zero data; read data is
    // only driven for an error-free read in its completing cycle.
    assign pready  = completing || (state_q == ABORT);
    assign pslverr = (state_q == ABORT) || (completing && err_q);
    assign prdata  = (completing && !pwrite_q && !err_q) ? rdData : '0;

endmodule

// File: tb/tb_apb_completer.sv
// tb_apb_completer
// Randomised + directed bench for apb_completer. A driver pushes the expected
// response of each transfer into a queue; a monitor pops and compares whenever
// pready is seen. Expectations come from a word-array reference model.
module tb_apb_completer;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NR      = 16;
    localparam int WS      = 1;
    localparam int LATENCY = WS + 1;

    localparam int MODE_NORMAL   = 0;
    localparam int MODE_ABORT    = 1;
    localparam int MODE_UNSTABLE = 2;

`ifdef APB_PSTRB_EN
    localparam bit PSTRB_EN = 1'b1;
`else
    localparam bit PSTRB_EN = 1'b0;
`endif

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } expect_t;

    logic        pclk = 1'b0;
    logic        reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          checks = 0;
    int          errors = 0;
    expect_t     expQ[$];
    logic [31:0] refRegs [NR];
    int          cyclesSinceSetup = -1;

    apb_completer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .WAIT_STATES (WS)
    ) dut (
        .pclk    (pclk),
        .reset   (reset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pprot   (pprot),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    // 100 MHz clock
    always #5 pclk = ~pclk;

    // Shared comparison helper; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Error rules of the completer expressed on the plain address value.
    function automatic logic predictErr(input logic wr, input logic [31:0] addr,
                                        input logic [3:0] strb, input logic [2:0] prot);
        logic [2:0] req;
        logic       e;
        req = 3'(addr >> 29);
        e   = 1'b0;
        if ((addr % 4) != 0) e = 1'b1;
        if (((addr >> 6) % 32'h0080_0000) != 0) e = 1'b1;
        if ((prot & req) != req) e = 1'b1;
        if (PSTRB_EN && !wr && (strb != 4'b0)) e = 1'b1;
        return e;
    endfunction

    // Predicts the response, updates the model, then drives one APB transfer.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [2:0] prot, input int mode);
        expect_t e;
        logic    err;
        int      idx;
        bit      done;
        err    = predictErr(wr, addr, strb, prot) || (mode != MODE_NORMAL);
        idx    = int'((addr >> 2) % NR);
        e.err  = err;
        e.data = (!wr && !err) ? refRegs[idx] : 32'h0;
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (!PSTRB_EN || strb[b]) refRegs[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        expQ.push_back(e);

        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb; pprot = prot;
        @(posedge pclk); #1;
        if (mode == MODE_ABORT) begin
            psel = 1'b0;
        end else begin
            penable = 1'b1;
            if (mode == MODE_UNSTABLE) paddr = addr ^ 32'h0000_0004;
        end
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge pclk);
            if (pready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: no pready for addr 0x%0h, expected within %0d cycles", addr, LATENCY);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Starts a write to 0x8 and asserts reset during its ACCESS phase.
    task automatic resetDuringWrite();
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8;
        pwdata = 32'hA5A5_A5A5; pstrb = 4'hF; pprot = 3'b000;
        @(posedge pclk); #1;
        penable = 1'b1; reset = 1'b1;
        @(posedge pclk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < NR; i++) refRegs[i] = 32'h0;
        @(negedge pclk);
        checkOutput("pready after mid-access reset", {31'b0, pready}, 32'h0);
    endtask

    // Monitor: measures setup-to-pready latency and checks each response
    // against the oldest queued expectation.
    always @(negedge pclk) begin
        if (reset) begin
            cyclesSinceSetup = -1;
        end else begin
            expect_t e;
            if (cyclesSinceSetup >= 0) cyclesSinceSetup++;
            if (psel && !penable && cyclesSinceSetup < 0) cyclesSinceSetup = 0;
            if (pready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected pready: got 1, expected 0");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("latency", 32'(cyclesSinceSetup), 32'(LATENCY));
                    checkOutput("pslverr", {31'b0, pslverr}, {31'b0, e.err});
                    checkOutput("prdata", prdata, e.data);
                end
                cyclesSinceSetup = -1;
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          idx;
        int          mode;
        int          pick;

        for (int i = 0; i < NR; i++) refRegs[i] = 32'h0;
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        checkOutput("reset pready", {31'b0, pready}, 32'h0);
        checkOutput("reset pslverr", {31'b0, pslverr}, 32'h0);
        checkOutput("reset prdata", prdata, 32'h0);
        @(posedge pclk); #1;
        reset = 1'b0;

        $display("[TB] directed transfers");
        applyStimulus(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 3'b000, MODE_NORMAL);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, MODE_NORMAL);
        applyStimulus(1'b0, 32'h3, 32'h0, 4'h0, 3'b000, MODE_NORMAL);
        applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, MODE_NORMAL);
        applyStimulus(1'b1, 32'hE000_0004, 32'h1234_5678, 4'hF, 3'b111, MODE_NORMAL);
        applyStimulus(1'b1, 32'hE000_0004, 32'h0BAD_0110, 4'hF, 3'b110, MODE_NORMAL);
        applyStimulus(1'b1, 32'hE000_0004, 32'h0BAD_0101, 4'hF, 3'b101, MODE_NORMAL);
        applyStimulus(1'b1, 32'hE000_0004, 32'h0BAD_0011, 4'hF, 3'b011, MODE_NORMAL);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, MODE_NORMAL);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, MODE_ABORT);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, MODE_NORMAL);
        applyStimulus(1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 3'b000, MODE_UNSTABLE);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, MODE_NORMAL);
        applyStimulus(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 3'b000, MODE_NORMAL);
        applyStimulus(1'b1, 32'h4, 32'h1122_3344, 4'b0011, 3'b000, MODE_NORMAL);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, MODE_NORMAL);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'b0100, 3'b000, MODE_NORMAL);
        resetDuringWrite();
        applyStimulus(1'b0, 32'h8, 32'h0, 4'h0, 3'b000, MODE_NORMAL);
        applyStimulus(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, MODE_NORMAL);

        $display("[TB] randomised transfers");
        for (int n = 0; n < 300; n++) begin
            idx = int'($urandom_range(NR - 1, 0));
            a   = 32'(idx) << 2;
            if ($urandom_range(1, 0) == 1) a[31:29] = 3'($urandom);
            pick = int'($urandom_range(99, 0));
            if (pick < 8)       a[1:0] = 2'($urandom_range(3, 1));
            else if (pick < 16) a[$urandom_range(28, 6)] = 1'b1;
            pick = int'($urandom_range(99, 0));
            mode = (pick < 5) ? MODE_ABORT : (pick < 10) ? MODE_UNSTABLE : MODE_NORMAL;
            applyStimulus(1'($urandom), a, $urandom,
                          ($urandom_range(4, 0) == 0) ? 4'($urandom) : 4'h0 | 4'($urandom & 32'h0),
                          3'($urandom), mode);
        end

        repeat (5) @(negedge pclk);
        checkOutput("expectation queue drained", 32'(expQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
